// File: rtl/aud_pkg.sv
// Shared types and sizing for the audio DAC serializer path.
package aud_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        SEND = 2'd2,
        PAD  = 2'd3
    } aud_i2s_state_e;

    localparam int AUD_WORD_W = 16;

    function automatic int aud_cnt_width(input int word_w);
        return $clog2(word_w);
    endfunction

    localparam int AUD_CNT_W = aud_cnt_width(AUD_WORD_W);

endpackage

// File: rtl/aud_lrclk_edge.sv
// Detects LR clock transitions in the bit-clock domain; edges are valid
// combinationally on the first bit-clock edge that samples the new level.
module aud_lrclk_edge (
    input  logic i_clk,
    input  logic i_daclrck,
    input  logic i_lrclk,
    output logic o_left_edge,
    output logic o_right_edge
);

    logic lrclk_r;
    logic edge_any;

    always_ff @(posedge i_clk or posedge i_daclrck) begin
        if (i_daclrck) begin
            lrclk_r <= 1'b0;
        end else begin
            lrclk_r <= i_lrclk;
        end
    end

    assign edge_any     = i_lrclk ^ lrclk_r;
    assign o_left_edge  = edge_any & ~i_lrclk;
    assign o_right_edge = edge_any & i_lrclk;

endmodule

// File: rtl/aud_i2s_player.sv
// I2S serializer for the WM8731 DAC line: MSB-first, one BCLK after LRCK.
// Define AUD_PLAYER_RIGHT_DUP_EN to repeat the left sample on the right channel.
module aud_i2s_player
    import aud_pkg::*;
#(
    parameter int DATA_W = AUD_WORD_W
) (
    input  logic              i_clk,
    input  logic              i_daclrck,
    input  logic              i_lrclk,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_dac_data,
    output logic              o_aud_dacdat,
    output logic              o_sample_req,
    output logic              o_busy,
    output aud_i2s_state_e    o_state
);

    localparam int CNT_W = aud_cnt_width(DATA_W);

`ifdef AUD_PLAYER_RIGHT_DUP_EN
    localparam bit RIGHT_DUP = 1'b1;
`else
    localparam bit RIGHT_DUP = 1'b0;
`endif

    aud_i2s_state_e    state;
    logic [DATA_W-1:0] shift_r;
    logic [DATA_W-1:0] hold_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              req_d;
    logic              left_edge;
    logic              right_edge;
    logic              start;
    logic [DATA_W-1:0] load_word;

    aud_lrclk_edge u_edge (
        .i_clk       (i_clk),
        .i_daclrck   (i_daclrck),
        .i_lrclk     (i_lrclk),
        .o_left_edge (left_edge),
        .o_right_edge(right_edge)
    );

    // A word only starts on a left edge from ARM; once running, either edge
    // restarts the shifter, which also cuts short a word on a short frame.
    always_comb begin
        start     = 1'b0;
        load_word = '0;
        if (state == ARM) begin
            start = left_edge;
        end else if (state == SEND || state == PAD) begin
            start = left_edge | right_edge;
        end
        if (left_edge) begin
            load_word = i_dac_data;
        end else if (RIGHT_DUP) begin
            load_word = hold_r;
        end
    end

    // o_sample_req is a one-cycle strobe with no back-pressure: the held
    // sample was consumed, so upstream may present the next one.
    always_ff @(posedge i_clk or posedge i_daclrck) begin
        if (i_daclrck) begin
            state        <= IDLE;
            shift_r      <= '0;
            hold_r       <= '0;
            cnt_r        <= '0;
            req_d        <= 1'b0;
            o_aud_dacdat <= 1'b0;
            o_sample_req <= 1'b0;
            o_busy       <= 1'b0;
        end else if (!i_en) begin
            state        <= IDLE;
            shift_r      <= '0;
            cnt_r        <= '0;
            req_d        <= 1'b0;
            o_aud_dacdat <= 1'b0;
            o_sample_req <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            o_sample_req <= req_d;
            req_d        <= 1'b0;
            if (start) begin
                shift_r      <= load_word;
                o_aud_dacdat <= load_word[DATA_W-1];
                cnt_r        <= CNT_W'(DATA_W - 1);
                state        <= SEND;
                o_busy       <= 1'b1;
                if (left_edge) begin
                    hold_r <= i_dac_data;
                    req_d  <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        state        <= ARM;
                        cnt_r        <= '0;
                        o_aud_dacdat <= 1'b0;
                        o_busy       <= 1'b0;
                    end
                    ARM: begin
                        o_aud_dacdat <= 1'b0;
                        o_busy       <= 1'b0;
                    end
                    SEND: begin
                        if (cnt_r == '0) begin
                            state        <= PAD;
                            o_aud_dacdat <= 1'b0;
                            o_busy       <= 1'b0;
                        end else begin
                            shift_r      <= shift_r << 1;
                            o_aud_dacdat <= shift_r[DATA_W-2];
                            cnt_r        <= cnt_r - 1'b1;
                        end
                    end
                    PAD: begin
                        o_aud_dacdat <= 1'b0;
                        o_busy       <= 1'b0;
                    end
                    default: begin
                        state        <= IDLE;
                        o_aud_dacdat <= 1'b0;
                        o_busy       <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_aud_i2s_player.sv
// Directed bench for aud_i2s_player: expected line/busy/request per BCLK
// derived from the I2S frame timing, queued and checked after each edge.
module tb_aud_i2s_player;
    import aud_pkg::*;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           lrclk = 1'b0;
    logic           en = 1'b0;
    logic [15:0]    dac_data = '0;
    logic           dacdat;
    logic           sample_req;
    logic           busy;
    aud_i2s_state_e st;

    int total = 0;
    int bad = 0;
    logic [2:0] exp_q[$];

    always #5 clk = ~clk;

    aud_i2s_player #(.DATA_W(16)) dut (
        .i_clk       (clk),
        .i_daclrck   (rst),
        .i_lrclk     (lrclk),
        .i_en        (en),
        .i_dac_data  (dac_data),
        .o_aud_dacdat(dacdat),
        .o_sample_req(sample_req),
        .o_busy      (busy),
        .o_state     (st)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] right_word(input logic [15:0] left_w);
`ifdef AUD_PLAYER_RIGHT_DUP_EN
        return left_w;
`else
        return 16'h0000;
`endif
    endfunction

    // One half-frame: lrclk is set to lr; j counts BCLK edges from edge n.
    task automatic half(input string tag, input logic lr, input int len,
                        input logic [15:0] word, input bit active);
        logic [2:0] e;
        lrclk = lr;
        for (int j = 0; j < len; j++) begin
            e = 3'b000;
            if (active) begin
                e[2] = (j < 16) ? word[15-j] : 1'b0;
                e[1] = (j < 16);
                e[0] = (lr == 1'b0) && (j == 1);
            end
            exp_q.push_back(e);
            tick();
            e = exp_q.pop_front();
            chk($sformatf("%s j=%0d dacdat/busy/req", tag, j), {29'd0, dacdat, busy, sample_req}, {29'd0, e});
        end
    endtask

    initial begin
        tick();
        tick();
        chk("reset dacdat", {31'd0, dacdat}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset req", {31'd0, sample_req}, 32'd0);
        chk("reset state", {30'd0, st}, {30'd0, IDLE});
        rst = 1'b0;

        half("dis_right", 1'b1, 8, 16'h0, 1'b0);
        en = 1'b1;
        half("arm_mid_right", 1'b1, 20, 16'h0, 1'b0);

        dac_data = 16'h8001;
        half("l8001a", 1'b0, 32, 16'h8001, 1'b1);
        half("r8001a", 1'b1, 32, right_word(16'h8001), 1'b1);
        half("l8001b", 1'b0, 32, 16'h8001, 1'b1);
        half("r8001b", 1'b1, 32, right_word(16'h8001), 1'b1);

        dac_data = 16'h7FFF;
        half("l7fff", 1'b0, 32, 16'h7FFF, 1'b1);
        half("r7fff", 1'b1, 32, right_word(16'h7FFF), 1'b1);

        dac_data = 16'hFFFF;
        for (int k = 0; k < 2; k++) begin
            half("short_l", 1'b0, 10, 16'hFFFF, 1'b1);
            half("short_r", 1'b1, 10, right_word(16'hFFFF), 1'b1);
        end

        dac_data = 16'h1234;
        half("l1234", 1'b0, 11, 16'h1234, 1'b1);
        en = 1'b0;
        half("drop_l", 1'b0, 21, 16'h0, 1'b0);
        chk("drop state", {30'd0, st}, {30'd0, IDLE});
        half("drop_r", 1'b1, 32, 16'h0, 1'b0);
        en = 1'b1;
        half("reen_r", 1'b1, 16, 16'h0, 1'b0);
        dac_data = 16'h4321;
        half("l4321", 1'b0, 32, 16'h4321, 1'b1);
        half("r4321", 1'b1, 32, right_word(16'h4321), 1'b1);

        dac_data = 16'hA5A5;
        half("la5a5_cut", 1'b0, 9, 16'hA5A5, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst dacdat", {31'd0, dacdat}, 32'd0);
        chk("async rst busy", {31'd0, busy}, 32'd0);
        chk("async rst state", {30'd0, st}, {30'd0, IDLE});
        @(posedge clk);
        #1;
        rst = 1'b0;
        half("post_rst_l", 1'b0, 10, 16'h0, 1'b0);
        half("post_rst_r", 1'b1, 32, 16'h0, 1'b0);
        half("la5a5", 1'b0, 32, 16'hA5A5, 1'b1);
        half("ra5a5", 1'b1, 32, right_word(16'hA5A5), 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aud_i2s_player.md
# aud_i2s_player

Downstream stage of the audio DSP. Takes the processed 16-bit sample and serializes it MSB-first onto the WM8731 DACDAT line in I2S format. Data is clocked by the codec bit clock and framed by the codec LR clock. Each left-channel frame start raises a one-cycle sample request, which tells the DSP that the held sample has been consumed.

## Interface
- DATA_W, 16, sample width; bits per channel word.
- i_clk  in  1  codec bit clock (AUD_BCLK); all registers on rising edge.
- i_daclrck  in  1  reset, asynchronous, active-high.
- i_lrclk  in  1  codec LR clock (AUD_DACLRCK); 0 = left, 1 = right.
- i_en  in  1  playback enable from top-level FSM, level.
- i_dac_data  in  DATA_W  signed sample from DSP; must be stable on the i_clk edge where the left frame starts.
- o_aud_dacdat  out  1  serial data to codec, registered.
- o_sample_req  out  1  one-cycle pulse: sample captured, upstream may advance.
- o_busy  out  1  high while a word is being shifted.

## Operation
- Frame edge detection:
  - lrclk_r holds i_lrclk from the previous i_clk edge.
  - edge = i_lrclk ^ lrclk_r.
  - left_edge = edge & ~i_lrclk.
  - right_edge = edge & i_lrclk.
- States: IDLE, ARM, SEND, PAD.
- IDLE:
  - o_aud_dacdat=0 and counter=0.
  - Goes to ARM when i_en=1.
- ARM:
  - Waits for left_edge. Never starts mid-frame or on a right edge.
  - On left_edge: capture i_dac_data into hold_r and shift_r, drive bit DATA_W-1, counter=DATA_W-1, go to SEND.
- SEND:
  - Each cycle: shift left, drive the next bit, decrement the counter.
  - After bit 0 has been driven (counter=0), go to PAD.
- PAD:
  - Drives 0 until the next edge.
- On any edge while in SEND or PAD:
  - left_edge: recapture i_dac_data.
  - right_edge: load the right word (see Configuration).
  - In both cases drive the MSB and enter SEND.
  - A short frame (edge while still in SEND) aborts the current word and reloads. No error flag.
- o_sample_req: pulses on the cycle after every left-edge capture.
- o_busy: equals (state==SEND).
- i_en=0 in any state: the next cycle goes to IDLE, o_aud_dacdat=0, the shift register clears, and no request is issued.
- Simultaneous edge and i_en falling: disable wins.
- Word bits are sent verbatim (two's complement). No arithmetic and no saturation.

## Timing
- Reset values: o_aud_dacdat=0, o_sample_req=0, o_busy=0, state=IDLE, lrclk_r=0, hold_r=0.
- Reset mid-word aborts immediately, asynchronously. After release, the block waits in ARM for a fresh left_edge.
- Let edge n be the first i_clk edge that samples the new i_lrclk level.
  - MSB is valid on o_aud_dacdat from edge n to edge n+1, so the codec samples it one BCLK after the LRCK transition (I2S delay).
  - Bit k is valid after edge n+(DATA_W-1-k).
  - LSB is valid after edge n+DATA_W-1.
  - Zeros from edge n+DATA_W until the next frame edge.
- o_sample_req is high after edge n+1 for exactly one cycle.
- Upstream (DSP on the LRCK domain) updates its sample on the LRCK rising edge. The sample is therefore stable for the whole left half-frame, and capture at the falling edge is always clean.
- Latency from i_dac_data capture to MSB on the line: 0 cycles (same edge).
- Frame length: a minimum of DATA_W+1 BCLK per half-frame gives a complete word.

## Configuration
- AUD_PLAYER_RIGHT_DUP_EN:
  - Defined: right_edge loads hold_r, so the right channel carries the same sample as the left (dual-mono).
  - Undefined: right_edge loads zero; the right channel outputs DATA_W zeros and o_busy still asserts.
- Left-channel behaviour is identical either way.

## Structure
- Package aud_pkg:
  - state enum aud_i2s_state_e {IDLE, ARM, SEND, PAD}.
  - localparam AUD_WORD_W=16.
  - helper width for the bit counter, $clog2(AUD_WORD_W).
- Sub-module aud_lrclk_edge:
  - Registers i_lrclk and outputs left_edge/right_edge.
  - Reset to 0 on i_daclrck.
- Top contains the FSM, shift register, hold register and counter.

## Test plan
- Reset asserted mid-word (i_dac_data=16'hA5A5, bit 7 on line) -> o_aud_dacdat=0, o_busy=0 immediately. After release, the next left edge sends A5A5 from the MSB.
- i_en=1, i_dac_data=16'h8001, LRCK period 64 BCLK -> after the left edge, line = 1,0×14,1 then 32−16 zeros. o_sample_req pulses once per frame on edge n+1.
- i_en rises while i_lrclk=1 (mid right half) -> nothing is sent until the following falling LRCK edge. First word equals i_dac_data at that edge.
- Right channel with i_dac_data=16'h7FFF: with the macro, the right word is 7FFF; without it, the right word is 16 zeros. The left word is 7FFF in both builds.
- Short frame: LRCK toggles every 10 BCLK, i_dac_data=16'hFFFF -> 10 ones then reload at each edge. o_busy never drops, and o_sample_req still pulses only on left edges.
- i_en dropped at bit 5 of 16'h1234 -> the line goes 0 on the next cycle and stays 0 with no sample requests. Re-enabling resumes at the next left edge.
